alu_issue_ctrl: RTL and testbench

Sequential controller that drives the 16-bit ALU datapath from the instruction side. It accepts one encoded instruction at a time over a valid/ready handshake and reads two operands from an internal 16×16 register file. It drives the ALU operand/select inputs, captures the combinational result and carry, writes the result back, and reports it on a result stream. It sits between the instruction source and the ALU in the Design 1 datapath.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_issue_ctrl_if.sv | 31 +++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and instruction-field helpers for the ALU issue controller.
// The instruction word is laid out as {op, rd, rs1, rs2}; LDI reuses the low byte as imm8.
package alu_pkg;

    localparam int W     = 16;
    localparam int NREGS = 16;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOTA = 4'h5,
        OP_NOTB = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_LDI  = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic [3:0] instr_op(input logic [15:0] i);
        return i[OP_LSB +: 4];
    endfunction

    function automatic logic [3:0] instr_rd(input logic [15:0] i);
        return i[RD_LSB +: 4];
    endfunction

    function automatic logic [3:0] instr_rs1(input logic [15:0] i);
        return i[RS1_LSB +: 4];
    endfunction

    function automatic logic [3:0] instr_rs2(input logic [15:0] i);
        return i[RS2_LSB +: 4];
    endfunction

    function automatic logic [7:0] instr_imm(input logic [15:0] i);
        return i[IMM_LSB +: 8];
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU and result-stream signals of the issue controller.
// master is the controller side; slave is the instruction source / ALU / consumer side.
interface alu_issue_ctrl_if #(
    parameter int W = 16
) ();

    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_sel;
    logic [W-1:0]  alu_result;
    logic          alu_carry;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_rd;
    logic [W-1:0]  res_data;
    logic          carry_flag;

    modport master (
        input  instr_valid, instr, alu_result, alu_carry, res_ready,
        output instr_ready, alu_a, alu_b, alu_sel, res_valid, res_rd, res_data, carry_flag
    );

    modport slave (
        output instr_valid, instr, alu_result, alu_carry, res_ready,
        input  instr_ready, alu_a, alu_b, alu_sel, res_valid, res_rd, res_data, carry_flag
    );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x W register file: two combinational read ports, one write port.
// The asynchronous reset clears every entry, so an aborted operation leaves no stale state.
module alu_regfile #(
    parameter int NREGS = 16,
    parameter int W     = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [W-1:0]  rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] regs_r [NREGS];

    // Storage array with asynchronous clear and single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end else begin
            regs_r[waddr] <= regs_r[waddr];
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external 16-bit ALU: accepts one instruction, drives the ALU
// from the register file, writes the result back and reports it on the result stream.
module alu_issue_ctrl #(
    parameter int NREGS = 16,
    parameter int W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.master bus
);

    import alu_pkg::*;

    localparam int AW = $clog2(NREGS);

    state_t        state_r;
    logic [15:0]   instr_r;
    logic          instr_ready_r;
    logic          res_valid_r;
    logic          carry_flag_r;
    logic [W-1:0]  alu_a_r;
    logic [W-1:0]  alu_b_r;
    logic [3:0]    alu_sel_r;
    logic [W-1:0]  res_data_r;
    logic [3:0]    res_rd_r;

    logic          accept_s;
    logic          we_s;
    logic [W-1:0]  wb_data_s;
    logic [W-1:0]  rdata_a_s;
    logic [W-1:0]  rdata_b_s;

    // Operands are read straight from the offered instruction so they are registered at accept
    alu_regfile #(
        .NREGS (NREGS),
        .W     (W),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we_s),
        .waddr   (AW'(instr_rd(instr_r))),
        .wdata   (wb_data_s),
        .raddr_a (AW'(instr_rs1(bus.instr))),
        .rdata_a (rdata_a_s),
        .raddr_b (AW'(instr_rs2(bus.instr))),
        .rdata_b (rdata_b_s)
    );

    // Handshake, write enable and writeback source selection (LDI bypasses the ALU)
    always_comb begin
        accept_s  = instr_ready_r & bus.instr_valid;
        we_s      = (state_r == EXEC);
        wb_data_s = bus.alu_result;
        if (instr_op(instr_r) == OP_LDI) begin
            wb_data_s = {{(W-8){1'b0}}, instr_imm(instr_r)};
        end else begin
            wb_data_s = bus.alu_result;
        end
    end

    // Issue FSM; every output is a register and ALU drives hold until the next EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            instr_r       <= 16'h0000;
            instr_ready_r <= 1'b0;
            res_valid_r   <= 1'b0;
            carry_flag_r  <= 1'b0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            alu_sel_r     <= 4'h0;
            res_data_r    <= '0;
            res_rd_r      <= 4'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        instr_r       <= bus.instr;
                        alu_a_r       <= rdata_a_s;
                        alu_b_r       <= rdata_b_s;
                        alu_sel_r     <= (instr_op(bus.instr) == OP_LDI) ? 4'h0
                                                                         : instr_op(bus.instr);
                        instr_ready_r <= 1'b0;
                        state_r       <= EXEC;
                    end else begin
                        instr_ready_r <= 1'b1;
                    end
                end
                EXEC: begin
                    res_data_r  <= wb_data_s;
                    res_rd_r    <= instr_rd(instr_r);
                    res_valid_r <= 1'b1;
                    if (instr_op(instr_r) == OP_ADD) begin
                        carry_flag_r <= bus.alu_carry;
                    end else begin
                        carry_flag_r <= carry_flag_r;
                    end
                    state_r <= WB;
                end
                WB: begin
                    if (bus.res_ready) begin
                        res_valid_r   <= 1'b0;
                        instr_ready_r <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        res_valid_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    instr_ready_r <= 1'b0;
                    res_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready = instr_ready_r;
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_sel     = alu_sel_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_rd      = res_rd_r;
    assign bus.res_data    = res_data_r;
    assign bus.carry_flag  = carry_flag_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, register-file model and a
// result scoreboard filled at issue time and drained on each result handshake.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
        logic        carry;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [15:0] m_rf [16];
    logic        m_carry;
    logic [15:0] shl_exp [3];

    alu_issue_ctrl_if #(.W(16)) bus ();

    alu_issue_ctrl #(.NREGS(16), .W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input logic [3:0] sel, input logic [15:0] a,
                                            input logic [15:0] b);
        case (sel)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return ~a;
            4'h6:    return ~b;
            4'h7:    return {a[14:0], 1'b0};
            4'h8:    return {1'b0, a[15:1]};
            default: return a;
        endcase
    endfunction

    // Behavioural ALU; carry is always the carry-out of A+B
    always_comb begin
        logic [16:0] sum;
        sum            = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result = ref_alu(bus.alu_sel, bus.alu_a, bus.alu_b);
        bus.alu_carry  = sum[16];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard drain on every result handshake
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_rd", 32'(bus.res_rd), 32'(e.rd));
                check_val("sb_data", 32'(bus.res_data), 32'(e.data));
                check_val("sb_carry", 32'(bus.carry_flag), 32'(e.carry));
            end
        end
    end

    task automatic model_exec(input logic [15:0] ins);
        logic [3:0]  op;
        logic [15:0] a, b, r;
        logic [16:0] sum;
        exp_t        e;
        op  = ins[15:12];
        a   = m_rf[ins[7:4]];
        b   = m_rf[ins[3:0]];
        sum = {1'b0, a} + {1'b0, b};
        if (op == 4'hF) r = {8'h00, ins[7:0]};
        else            r = ref_alu(op, a, b);
        if (op == 4'h0) m_carry = sum[16];
        m_rf[ins[11:8]] = r;
        e.rd    = ins[11:8];
        e.data  = r;
        e.carry = m_carry;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.instr_ready && n < 20) begin
            step();
            n++;
        end
        check_val("ready_wait", 32'(bus.instr_ready), 32'd1);
    endtask

    task automatic issue(input logic [15:0] ins);
        logic [15:0] ea, eb;
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        step();
        bus.instr_valid = 1'b0;
        ea = m_rf[ins[7:4]];
        eb = m_rf[ins[3:0]];
        model_exec(ins);
        check_val("exec_valid", 32'(bus.res_valid), 32'd0);
        check_val("exec_ready", 32'(bus.instr_ready), 32'd0);
        if (ins[15:12] != 4'hF) begin
            check_val("exec_alu_a", 32'(bus.alu_a), 32'(ea));
            check_val("exec_alu_b", 32'(bus.alu_b), 32'(eb));
            check_val("exec_sel", 32'(bus.alu_sel), 32'(ins[15:12]));
        end else begin
            check_val("exec_sel_ldi", 32'(bus.alu_sel), 32'h0);
        end
        step();
        check_val("wb_valid", 32'(bus.res_valid), 32'd1);
        step();
        check_val("idle_valid", 32'(bus.res_valid), 32'd0);
        check_val("idle_ready", 32'(bus.instr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr     = 16'h0000;
        bus.res_ready = 1'b1;
        m_carry       = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        shl_exp[0] = 16'h01FE;
        shl_exp[1] = 16'h03FC;
        shl_exp[2] = 16'h07F8;

        #2;
        check_val("rst_ready", 32'(bus.instr_ready), 32'd0);
        check_val("rst_valid", 32'(bus.res_valid), 32'd0);
        check_val("rst_alu_a", 32'(bus.alu_a), 32'h0);
        check_val("rst_alu_b", 32'(bus.alu_b), 32'h0);
        check_val("rst_sel", 32'(bus.alu_sel), 32'h0);
        check_val("rst_data", 32'(bus.res_data), 32'h0);
        check_val("rst_rd", 32'(bus.res_rd), 32'h0);
        check_val("rst_carry", 32'(bus.carry_flag), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check_val("post_rst_ready", 32'(bus.instr_ready), 32'd1);

        // LDI r1,0xFF; LDI r2,0x01; ADD r3,r1,r2
        issue(16'hF1FF);
        issue(16'hF201);
        issue(16'h0312);
        check_val("add_data", 32'(bus.res_data), 32'h0100);
        check_val("add_rd", 32'(bus.res_rd), 32'h3);
        check_val("add_carry", 32'(bus.carry_flag), 32'd0);

        // NOT r5,r0; ADD r6,r5,r2 sets carry; SUB keeps it
        issue(16'h5500);
        check_val("nota_data", 32'(bus.res_data), 32'hFFFF);
        issue(16'h0652);
        check_val("addc_data", 32'(bus.res_data), 32'h0000);
        check_val("addc_carry", 32'(bus.carry_flag), 32'd1);
        issue(16'h1712);
        check_val("sub_data", 32'(bus.res_data), 32'h00FE);
        check_val("sub_carry", 32'(bus.carry_flag), 32'd1);

        // Back-pressure: hold res_ready low for 5 cycles with an instruction offered
        wait_ready();
        bus.res_ready   = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0312;
        step();
        bus.instr = 16'hF955;
        model_exec(16'h0312);
        step();
        for (int i = 0; i < 5; i++) begin
            check_val("hold_valid", 32'(bus.res_valid), 32'd1);
            check_val("hold_data", 32'(bus.res_data), 32'h0100);
            check_val("hold_rd", 32'(bus.res_rd), 32'h3);
            check_val("hold_ready", 32'(bus.instr_ready), 32'd0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        check_val("hold_idle_ready", 32'(bus.instr_ready), 32'd1);
        check_val("hold_idle_valid", 32'(bus.res_valid), 32'd0);
        step();
        bus.instr_valid = 1'b0;
        model_exec(16'hF955);
        check_val("late_exec_valid", 32'(bus.res_valid), 32'd0);
        check_val("late_exec_ready", 32'(bus.instr_ready), 32'd0);
        step();
        check_val("late_wb_valid", 32'(bus.res_valid), 32'd1);
        check_val("late_wb_data", 32'(bus.res_data), 32'h0055);
        step();

        // Reserved op passes A through
        issue(16'hA810);
        check_val("rsvd_data", 32'(bus.res_data), 32'h00FF);

        // In-place shift, back to back
        for (int i = 0; i < 3; i++) begin
            issue(16'h7110);
            check_val("shl_data", 32'(bus.res_data), 32'(shl_exp[i]));
        end

        // Set carry, then abort mid-EXEC with reset
        issue(16'h0652);
        check_val("pre_rst_carry", 32'(bus.carry_flag), 32'd1);
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h0312;
        step();
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("abort_valid", 32'(bus.res_valid), 32'd0);
        check_val("abort_ready", 32'(bus.instr_ready), 32'd0);
        check_val("abort_alu_a", 32'(bus.alu_a), 32'h0);
        check_val("abort_sel", 32'(bus.alu_sel), 32'h0);
        check_val("abort_data", 32'(bus.res_data), 32'h0);
        check_val("abort_rd", 32'(bus.res_rd), 32'h0);
        check_val("abort_carry", 32'(bus.carry_flag), 32'd0);
        m_carry = 1'b0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(16'h0312);
        check_val("rst_add_data", 32'(bus.res_data), 32'h0000);
        check_val("rst_add_carry", 32'(bus.carry_flag), 32'd0);

        step();
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
